// File: rtl/cnn_pkg.sv
// cnn_pkg: shared image geometry and window flatten rule for the CNN front end
package cnn_pkg;
  localparam int PIX_W   = 8;
  localparam int COORD_W = 5;
  localparam int IMG_W   = 28;
  localparam int IMG_H   = 28;
  localparam int KERNEL  = 3;
  function automatic int win_idx(input int i, input int j);
    return KERNEL * i + j;
  endfunction
endpackage

// File: rtl/conv_window_ctrl_if.sv
// conv_window_ctrl_if: pixel-in / window-out stream handshake bundle
interface conv_window_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 5
);
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [9*DW-1:0] out_win;
  logic [AW-1:0]   out_row;
  logic [AW-1:0]   out_col;
  logic            out_last;
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_win, out_row, out_col, out_last
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_win, out_row, out_col, out_last
  );
endinterface

// File: rtl/lb_dpram.sv
// lb_dpram: single-clock line buffer with registered, read-before-write read port
module lb_dpram #(
  parameter int DW    = 8,
  parameter int AW    = 5,
  parameter int DEPTH = 28
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (re) rd <= mem[raddr];
    if (we) mem[waddr] <= wd;
  end
endmodule

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: raster pixel stream to 3x3 windows using two ping-pong line buffers
module conv_window_ctrl
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_W,
  parameter int ADDR_WIDTH = COORD_W,
  parameter int IMG_WIDTH  = IMG_W,
  parameter int IMG_HEIGHT = IMG_H
) (
  input logic clk,
  input logic rst_n,
  input logic clr,
  conv_window_ctrl_if.slave s
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  logic en, take, col_end, row_end, fresh;
  logic v0, s1v, ov, olast;
  logic [AW-1:0] row, col, r0, c0, s1r, s1c, orow, ocol;
  logic [DW-1:0] q0, q1, p0, s1p, s1t, s1m;
  logic [9*DW-1:0] w, wn, ow;
  assign en      = !ov || s.out_ready;
  assign take    = s.in_valid && en && !clr;
  assign col_end = col == AW'(IMG_WIDTH - 1);
  assign row_end = row == AW'(IMG_HEIGHT - 1);
  assign fresh   = s1v && s1r >= AW'(2) && s1c >= AW'(2);
  assign s.in_ready  = en;
  assign s.out_valid = ov;
  assign s.out_win   = ow;
  assign s.out_row   = orow;
  assign s.out_col   = ocol;
  assign s.out_last  = olast;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (take) begin
      col <= col_end ? '0 : col + 1'b1;
      row <= col_end ? (row_end ? '0 : row + 1'b1) : row;
    end
  // buffer[row[0]] still holds row-2 at this column when it is overwritten
  lb_dpram #(.DW(DW), .AW(AW), .DEPTH(IMG_WIDTH)) u_lb0 (
    .clk(clk), .we(take && !row[0]), .re(take), .waddr(col), .raddr(col), .wd(s.in_data), .rd(q0)
  );
  lb_dpram #(.DW(DW), .AW(AW), .DEPTH(IMG_WIDTH)) u_lb1 (
    .clk(clk), .we(take && row[0]), .re(take), .waddr(col), .raddr(col), .wd(s.in_data), .rd(q1)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v0 <= 1'b0;
      p0 <= '0;
      r0 <= '0;
      c0 <= '0;
    end else if (clr) begin
      v0 <= 1'b0;
    end else if (en) begin
      v0 <= take;
      if (take) begin
        p0 <= s.in_data;
        r0 <= row;
        c0 <= col;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1v <= 1'b0;
      s1p <= '0;
      s1t <= '0;
      s1m <= '0;
      s1r <= '0;
      s1c <= '0;
    end else if (clr) begin
      s1v <= 1'b0;
    end else if (en) begin
      s1v <= v0;
      if (v0) begin
        s1p <= p0;
        s1t <= r0[0] ? q1 : q0;
        s1m <= r0[0] ? q0 : q1;
        s1r <= r0;
        s1c <= c0;
      end
    end
  always_comb begin
    wn = w;
    for (int i = 0; i < KERNEL; i++) begin
      wn[win_idx(i, 0)*DW +: DW] = w[win_idx(i, 1)*DW +: DW];
      wn[win_idx(i, 1)*DW +: DW] = w[win_idx(i, 2)*DW +: DW];
    end
    wn[win_idx(0, 2)*DW +: DW] = s1t;
    wn[win_idx(1, 2)*DW +: DW] = s1m;
    wn[win_idx(2, 2)*DW +: DW] = s1p;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w     <= '0;
      ov    <= 1'b0;
      ow    <= '0;
      orow  <= '0;
      ocol  <= '0;
      olast <= 1'b0;
    end else if (clr) begin
      ov <= 1'b0;
    end else if (en) begin
      if (s1v) w <= wn;
      ov <= fresh;
      if (fresh) begin
        ow    <= wn;
        orow  <= s1r - AW'(2);
        ocol  <= s1c - AW'(2);
        olast <= s1r == AW'(IMG_HEIGHT - 1) && s1c == AW'(IMG_WIDTH - 1);
      end
    end
endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: randomized scoreboard bench with an image-array reference model
module tb_conv_window_ctrl;
  import cnn_pkg::*;
  localparam int W = IMG_W, H = IMG_H, DW = PIX_W, AW = COORD_W;
  localparam int NWIN = (W - 2) * (H - 2);
  typedef struct {
    logic [9*DW-1:0] win;
    logic [AW-1:0]   row, col;
    logic            last;
    int              t;
    bit              lat;
  } exp_t;
  logic clk = 0, rst_n = 0, clr = 0;
  always #5 clk = ~clk;
  conv_window_ctrl_if #(.DW(DW), .AW(AW)) bus ();
  conv_window_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .s(bus)
  );
  exp_t sbq[$];
  logic [DW-1:0] img [H][W];
  int checks = 0, failures = 0, cyc = 0, nwin = 0, nlast = 0, mr = 0, mc = 0;
  bit lat_mode = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask
  // expected window is cut directly out of the stored image
  task automatic model_accept(input logic [DW-1:0] d);
    exp_t e;
    img[mr][mc] = d;
    if (mr >= 2 && mc >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) e.win[(3*i+j)*DW +: DW] = img[mr-2+i][mc-2+j];
      e.row = AW'(mr - 2);
      e.col = AW'(mc - 2);
      e.last = (mr == H - 1) && (mc == W - 1);
      e.t = cyc + 1;
      e.lat = lat_mode;
      sbq.push_back(e);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end
  endtask
  task automatic run(input int npix, input int vp, input int rp, input bit ramp);
    int got = 0, guard = 0;
    while (got < npix && guard < npix * 20 + 100) begin
      @(negedge clk);
      bus.in_valid = $urandom_range(99) < vp;
      bus.in_data = ramp ? DW'((mr * W + mc) % 256) : DW'($urandom);
      bus.out_ready = $urandom_range(99) < rp;
      #1;
      if (bus.in_valid && bus.in_ready) begin
        model_accept(bus.in_data);
        got++;
      end
      guard++;
    end
    check("accepted", got, npix);
  endtask
  task automatic drain();
    int k = 0;
    @(negedge clk);
    bus.in_valid = 0;
    bus.out_ready = 1;
    while (sbq.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("drain", sbq.size(), 0);
  endtask
  task automatic idle();
    @(negedge clk);
    bus.in_valid = 0;
    bus.out_ready = 1;
    @(negedge clk);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_win"}, bus.out_win, 0);
    check({tag, "_row"}, bus.out_row, 0);
    check({tag, "_col"}, bus.out_col, 0);
    check({tag, "_last"}, bus.out_last, 0);
    check({tag, "_in_ready"}, bus.in_ready, 1);
  endtask
  // monitor: pops and compares on every handshake, and checks stalled outputs hold
  initial begin
    exp_t e;
    bit pstall = 0;
    logic [9*DW+2*AW:0] pval = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) pstall = 0;
      else begin
        if (pstall) begin
          check("hold_valid", bus.out_valid, 1);
          check("hold_data", {bus.out_win, bus.out_row, bus.out_col, bus.out_last}, pval);
        end
        pstall = bus.out_valid && !bus.out_ready;
        pval = {bus.out_win, bus.out_row, bus.out_col, bus.out_last};
        if (bus.out_valid && bus.out_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_window actual row=%0d col=%0d required none", bus.out_row, bus.out_col);
          end else begin
            e = sbq.pop_front();
            check("win", bus.out_win, e.win);
            check("coord", {bus.out_row, bus.out_col, bus.out_last}, {e.row, e.col, e.last});
            if (e.lat) check("latency", cyc, e.t + 2);
          end
          nwin++;
          if (bus.out_last) nlast++;
        end
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n0, l0;
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.out_ready = 1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1;
    lat_mode = 1;
    n0 = nwin; l0 = nlast;
    run(W * H, 100, 100, 1);
    drain();
    lat_mode = 0;
    check("count_full", nwin - n0, NWIN);
    check("last_full", nlast - l0, 1);
    n0 = nwin;
    run(W * H, 100, 50, 1);
    drain();
    check("count_stall", nwin - n0, NWIN);
    n0 = nwin;
    run(W * H, 60, 100, 1);
    drain();
    check("count_gaps", nwin - n0, NWIN);
    n0 = nwin; l0 = nlast;
    run(2 * W * H, 80, 70, 0);
    drain();
    check("count_2frames", nwin - n0, 2 * NWIN);
    check("last_2frames", nlast - l0, 2);
    run(10 * W + 5, 100, 70, 1);
    idle();
    rst_n = 0;
    sbq.delete();
    mr = 0; mc = 0;
    #1;
    check_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    n0 = nwin;
    run(W * H, 90, 80, 1);
    drain();
    check("count_after_reset", nwin - n0, NWIN);
    run(3 * W + 7, 100, 100, 0);
    idle();
    clr = 1;
    bus.in_valid = 1;
    bus.in_data = DW'($urandom);
    @(posedge clk);
    #1;
    sbq.delete();
    mr = 0; mc = 0;
    @(negedge clk);
    clr = 0;
    bus.in_valid = 0;
    n0 = nwin;
    run(W * H, 90, 80, 0);
    drain();
    check("count_after_clr", nwin - n0, NWIN);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Sequencer that turns a raster grayscale pixel stream into 3x3 convolution windows for the CNN front end. Owns two single-row line buffers in ping-pong, generates their write/read addresses and enables, and assembles the window registers. Sits between the grayscale pixel source and the first convolution layer, and delivers one window per accepted pixel once two full rows and two columns are buffered.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width
- ADDR_WIDTH, 5, line-buffer address / coordinate width
- IMG_WIDTH, 28, pixels per row
- IMG_HEIGHT, 28, rows per frame

Ports:
- clk  in  1  single clock for all logic and both line buffers
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous frame restart; same effect as reset on counters and valids
- in_valid  in  1  pixel present
- in_data  in  DATA_WIDTH  pixel value
- in_ready  out  1  pixel accepted when in_valid && in_ready
- out_valid  out  1  window present
- out_ready  in  1  window consumed when out_valid && out_ready
- out_win  out  9*DATA_WIDTH  window; element (i,j) at [(3*i+j)*DATA_WIDTH +: DATA_WIDTH], i=0 oldest row, j=0 leftmost column
- out_row  out  ADDR_WIDTH  top-left row of window, 0..IMG_HEIGHT-3
- out_col  out  ADDR_WIDTH  top-left column of window, 0..IMG_WIDTH-3
- out_last  out  1  high with the final window of the frame

## Operation
- Global advance en = !out_valid || out_ready; in_ready = en (combinational). Accept = in_valid && en.
- Counters col (0..IMG_WIDTH-1), row (0..IMG_HEIGHT-1) step on accept; col wraps to 0 and increments row; at (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0 (next frame starts with no gap).
- Ping-pong: sel = row[0]. On accept: read both buffers at address col, and write in_data into buffer[sel] at col. Buffer read is registered and read-before-write, so buffer[sel] returns row-2 and buffer[!sel] returns row-1 for that column.
- Stage 1 (one cycle after accept): holds current pixel, row-2 and row-1 samples, plus row/col tags. When s1_valid && en, shift the 3x3 register left by one column, load new right column {row-2, row-1, current}.
- Window valid when the stage-1 tags satisfy row>=2 && col>=2; then load out_win, out_row=row-2, out_col=col-2, out_last=(row==IMG_HEIGHT-1 && col==IMG_WIDTH-1), set out_valid. Otherwise, on en, clear out_valid.
- Stale columns from the previous row in the shift register are never emitted: col>=2 gating guarantees three fresh columns.
- Line-buffer contents are never cleared; rows 0 and 1 of each frame overwrite them before use.
- clr: counters to 0, s1_valid and out_valid to 0 on the next edge; takes priority over a simultaneous accept (that pixel is dropped).

## Timing
- Reset values: out_valid=0, out_win=0, out_row=0, out_col=0, out_last=0, counters 0, s1_valid=0; hence in_ready=1 from reset.
- Latency: pixel accepted at edge T yields its window (as bottom-right element) at out_valid after edge T+2.
- Throughput: one window per cycle at full rate; 676 windows per 28x28 frame.
- Backpressure: out_valid && !out_ready freezes counters, stage 1, buffer enables and outputs; out_* stable until taken.
- in_valid gaps: nothing advances; window sequence unchanged.
- Reset mid-frame: everything above returns to reset values immediately; next accepted pixel is (0,0).

## Structure
- Shared package cnn_pkg: IMG_WIDTH, IMG_HEIGHT, DATA_WIDTH, KERNEL=3, window flatten index rule.
- One sub-module: lb_dpram (single-clock, registered-read, write-enable, read-enable, depth IMG_WIDTH), instantiated twice.

## Test plan
- Ramp frame, pixel=(r*28+c) mod 256, in_valid always high, out_ready=1 -> first window 2 cycles after pixel (2,2); out_win rows {0,1,2},{28,29,30},{56,57,58}; out_row=0, out_col=0.
- Same frame -> exactly 676 windows, coordinates in raster order, out_last only on (25,25) with bottom-right element 783 mod 256 = 15.
- Random out_ready 50% -> window sequence identical to full-rate run; out_win/out_row/out_col held while stalled; no pixel lost.
- Random in_valid gaps -> identical window sequence to full-rate run.
- Two back-to-back frames -> second frame windows correct, first window of frame 2 at (0,0), no window spanning frames.
- rst_n low at pixel (10,5), then new frame -> outputs zero during reset; new frame windows correct from (0,0); clr asserted with in_valid high -> that pixel dropped, counters 0.
